// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared types and constants for the tri-state delay driver.
//   DLY_W    : width of every delay countdown
//   DLY_MAX  : largest delay a parameter may request
//   d_state_t: data-path FSM encoding   (D_IDLE, D_PEND)
//   e_state_t: enable-path FSM encoding (E_OFF, E_ON, E_DRAIN)
// -----------------------------------------------------------------------------
package delay_pkg;

  localparam int DLY_W   = 4;
  localparam int DLY_MAX = 15;

  // Data path: IDLE means din == dout, PEND means a change is being timed.
  typedef logic [0:0] d_state_t;
  localparam d_state_t D_IDLE = 1'b0;
  localparam d_state_t D_PEND = 1'b1;

  // Enable path: DRAIN keeps the pad driven while oe has been low too briefly.
  typedef logic [1:0] e_state_t;
  localparam e_state_t E_OFF   = 2'd0;
  localparam e_state_t E_ON    = 2'd1;
  localparam e_state_t E_DRAIN = 2'd2;

endpackage

// File: rtl/tri_delay_driver_if.sv
// -----------------------------------------------------------------------------
// tri_delay_driver_if
// Signal bundle between a tri-state delay driver and its user.
//   din     : data to be delayed                 (master -> slave)
//   oe      : requested output enable            (master -> slave)
//   dout    : delayed, inertially filtered data  (slave -> master)
//   dout_en : pad driver enable                  (slave -> master)
//   busy    : a delay countdown is pending       (slave -> master)
// -----------------------------------------------------------------------------
interface tri_delay_driver_if;

  logic din;
  logic oe;
  logic dout;
  logic dout_en;
  logic busy;

  modport master (output din, oe, input dout, dout_en, busy);
  modport slave  (input din, oe, output dout, dout_en, busy);

endinterface

// File: rtl/inertial_cnt.sv
// -----------------------------------------------------------------------------
// inertial_cnt
// One saturating down-counter used to time an inertial delay.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; ignored when the count is already zero
//   last     : count is 1, so the decrement on this edge reaches zero
// -----------------------------------------------------------------------------
module inertial_cnt
  import delay_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [DLY_W-1:0] cnt;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  // The owner acts on the edge whose decrement lands on zero, which makes a
  // load of D-1 produce exactly D cycles of latency from the first sample.
  assign last = (cnt == DLY_W'(1));

endmodule

// File: rtl/tri_delay_driver.sv
// -----------------------------------------------------------------------------
// tri_delay_driver
// Inertial delay on data plus a delayed turn-off on the pad enable.
// A din change must hold for RISE_DLY/FALL_DLY cycles before dout follows;
// shorter pulses are swallowed. dout_en turns on one cycle after oe and turns
// off only after oe has been low OFF_DLY cycles in a row.
//   Parameters: RISE_DLY, FALL_DLY, OFF_DLY (each 1..15)
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : tri_delay_driver_if.slave (din, oe in; dout, dout_en, busy out)
//   pad  : inout pad, driven with dout while dout_en=1, else 'z
//          (present only when TRI_DELAY_PAD_EN is defined)
// -----------------------------------------------------------------------------
module tri_delay_driver
  import delay_pkg::*;
#(
  parameter int RISE_DLY = 2,
  parameter int FALL_DLY = 1,
  parameter int OFF_DLY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  tri_delay_driver_if.slave bus
`ifdef TRI_DELAY_PAD_EN
  ,
  inout  wire               pad
`endif
);

  if (RISE_DLY < 1 || RISE_DLY > DLY_MAX) begin : g_bad_rise
    $error("tri_delay_driver: RISE_DLY=%0d outside 1..%0d", RISE_DLY, DLY_MAX);
  end
  if (FALL_DLY < 1 || FALL_DLY > DLY_MAX) begin : g_bad_fall
    $error("tri_delay_driver: FALL_DLY=%0d outside 1..%0d", FALL_DLY, DLY_MAX);
  end
  if (OFF_DLY < 1 || OFF_DLY > DLY_MAX) begin : g_bad_off
    $error("tri_delay_driver: OFF_DLY=%0d outside 1..%0d", OFF_DLY, DLY_MAX);
  end

  localparam logic [DLY_W-1:0] RISE_LOAD = DLY_W'(RISE_DLY - 1);
  localparam logic [DLY_W-1:0] FALL_LOAD = DLY_W'(FALL_DLY - 1);
  localparam logic [DLY_W-1:0] OFF_LOAD  = DLY_W'(OFF_DLY - 1);

  // ---------------------------------------------------------------- data path
  d_state_t         d_state, d_state_n;
  logic             dout_q, dout_n;
  logic             d_load, d_dec, d_last;
  logic [DLY_W-1:0] d_load_val;

  inertial_cnt u_data_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (d_load),
    .load_val (d_load_val),
    .dec      (d_dec),
    .last     (d_last)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    d_state_n  = d_state;
    dout_n     = dout_q;
    d_load     = 1'b0;
    d_dec      = 1'b0;
    d_load_val = bus.din ? RISE_LOAD : FALL_LOAD;
    case (d_state)
      D_IDLE: begin
        if (bus.din != dout_q) begin
          if (d_load_val == '0) begin
            dout_n = bus.din;             // one-cycle delay: plain register
          end else begin
            d_load    = 1'b1;
            d_state_n = D_PEND;
          end
        end
      end
      D_PEND: begin
        if (bus.din == dout_q) begin
          d_state_n = D_IDLE;             // pulse too short, rejected
        end else begin
          d_dec = 1'b1;
          if (d_last) begin
            dout_n    = bus.din;
            d_state_n = D_IDLE;
          end
        end
      end
      default: d_state_n = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      dout_q  <= 1'b0;
    end else begin
      d_state <= d_state_n;
      dout_q  <= dout_n;
    end
  end

  // -------------------------------------------------------------- enable path
  e_state_t e_state, e_state_n;
  logic     en_q, en_n;
  logic     e_load, e_dec, e_last;

  inertial_cnt u_en_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (e_load),
    .load_val (OFF_LOAD),
    .dec      (e_dec),
    .last     (e_last)
  );

  always_comb begin
    e_state_n = e_state;
    en_n      = en_q;
    e_load    = 1'b0;
    e_dec     = 1'b0;
    case (e_state)
      E_OFF: begin
        if (bus.oe) begin
          en_n      = 1'b1;
          e_state_n = E_ON;
        end
      end
      E_ON: begin
        if (!bus.oe) begin
          if (OFF_LOAD == '0) begin
            en_n      = 1'b0;
            e_state_n = E_OFF;
          end else begin
            e_load    = 1'b1;
            e_state_n = E_DRAIN;
          end
        end
      end
      E_DRAIN: begin
        if (bus.oe) begin
          e_state_n = E_ON;               // oe came back before the drain ended
        end else begin
          e_dec = 1'b1;
          if (e_last) begin
            en_n      = 1'b0;
            e_state_n = E_OFF;
          end
        end
      end
      default: begin
        en_n      = 1'b0;
        e_state_n = E_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_state <= E_OFF;
      en_q    <= 1'b0;
    end else begin
      e_state <= e_state_n;
      en_q    <= en_n;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign bus.dout    = dout_q;
  assign bus.dout_en = en_q;
  assign bus.busy    = (d_state == D_PEND) || (e_state == E_DRAIN);

`ifdef TRI_DELAY_PAD_EN
  assign pad = en_q ? dout_q : 1'bz;
`endif

endmodule

// File: tb/tb_tri_delay_driver.sv
// -----------------------------------------------------------------------------
// tb_tri_delay_driver
// Three configurations share one stimulus stream: defaults (2/1/3), a slow
// rise (15/1/3) and the all-ones plain-register case (1/1/1). Each is compared
// every cycle with a run-length model: dout follows din once din has differed
// from dout for D consecutive samples; dout_en drops once oe has been low for
// OFF_DLY consecutive samples while enabled. Directed steps come first, then
// randomized traffic. Pad checks are compiled in with TRI_DELAY_PAD_EN.
// -----------------------------------------------------------------------------
module tb_tri_delay_driver;

  localparam int A_RISE = 2,  A_FALL = 1, A_OFF = 3;
  localparam int B_RISE = 15, B_FALL = 1, B_OFF = 3;
  localparam int C_RISE = 1,  C_FALL = 1, C_OFF = 1;

  logic clk;
  logic rst;
  logic din;
  logic oe;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tri_delay_driver_if bus_a ();
  tri_delay_driver_if bus_b ();
  tri_delay_driver_if bus_c ();

  assign bus_a.din = din;
  assign bus_a.oe  = oe;
  assign bus_b.din = din;
  assign bus_b.oe  = oe;
  assign bus_c.din = din;
  assign bus_c.oe  = oe;

`ifdef TRI_DELAY_PAD_EN
  wire pad_a, pad_b, pad_c;
`endif

  tri_delay_driver #(.RISE_DLY(A_RISE), .FALL_DLY(A_FALL), .OFF_DLY(A_OFF)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
`ifdef TRI_DELAY_PAD_EN
    , .pad (pad_a)
`endif
  );

  tri_delay_driver #(.RISE_DLY(B_RISE), .FALL_DLY(B_FALL), .OFF_DLY(B_OFF)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
`ifdef TRI_DELAY_PAD_EN
    , .pad (pad_b)
`endif
  );

  tri_delay_driver #(.RISE_DLY(C_RISE), .FALL_DLY(C_FALL), .OFF_DLY(C_OFF)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
`ifdef TRI_DELAY_PAD_EN
    , .pad (pad_c)
`endif
  );

  // Behavioural model: only run lengths, no states or countdowns.
  typedef struct {
    bit dout;
    bit en;
    int run;      // consecutive samples with din != dout
    int off_run;  // consecutive samples with oe = 0 while enabled
  } model_t;

  model_t m_a, m_b, m_c;

  function automatic void model_clear(output model_t m);
    m.dout    = 1'b0;
    m.en      = 1'b0;
    m.run     = 0;
    m.off_run = 0;
  endfunction

  function automatic void model_step(inout model_t m, input bit d, input bit o,
                                     input int rise, input int fall, input int off);
    if (d != m.dout) begin
      m.run++;
      if (m.run == (d ? rise : fall)) begin
        m.dout = d;
        m.run  = 0;
      end
    end else begin
      m.run = 0;
    end
    if (!m.en) begin
      m.off_run = 0;
      if (o) m.en = 1'b1;
    end else if (o) begin
      m.off_run = 0;
    end else begin
      m.off_run++;
      if (m.off_run == off) begin
        m.en      = 1'b0;
        m.off_run = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string name, input model_t m,
                           input logic d, input logic e, input logic b);
    check({name, ".dout"},    d, m.dout);
    check({name, ".dout_en"}, e, m.en);
    check({name, ".busy"},    b, logic'((m.run > 0) || (m.off_run > 0)));
  endtask

`ifdef TRI_DELAY_PAD_EN
  task automatic check_pad(input string name, input model_t m, input logic p);
    check({name, ".pad"}, p, m.en ? logic'(m.dout) : 1'bz);
  endtask
`endif

  // Drive one cycle of inputs, advance the models on the same edge, then
  // compare every DUT output 1 time unit after the edge.
  task automatic step(input logic d, input logic o, input logic r);
    din = d;
    oe  = o;
    rst = r;
    @(posedge clk);
    if (r) begin
      model_clear(m_a);
      model_clear(m_b);
      model_clear(m_c);
    end else begin
      model_step(m_a, d, o, A_RISE, A_FALL, A_OFF);
      model_step(m_b, d, o, B_RISE, B_FALL, B_OFF);
      model_step(m_c, d, o, C_RISE, C_FALL, C_OFF);
    end
    #1;
    check_dut("a", m_a, bus_a.dout, bus_a.dout_en, bus_a.busy);
    check_dut("b", m_b, bus_b.dout, bus_b.dout_en, bus_b.busy);
    check_dut("c", m_c, bus_c.dout, bus_c.dout_en, bus_c.busy);
`ifdef TRI_DELAY_PAD_EN
    check_pad("a", m_a, pad_a);
    check_pad("b", m_b, pad_b);
    check_pad("c", m_c, pad_c);
`endif
  endtask

  initial begin
    logic d, o, r;
    din = 1'b0;
    oe  = 1'b0;
    rst = 1'b1;
    model_clear(m_a);
    model_clear(m_b);
    model_clear(m_c);

    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_dout",    bus_a.dout,    1'b0);
    check("rst_dout_en", bus_a.dout_en, 1'b0);
    check("rst_busy",    bus_a.busy,    1'b0);

    // Rise after 2 cycles, held 5 cycles, then fall after 1 cycle.
    step(1'b1, 1'b0, 1'b0);
    check("rise_wait", bus_a.dout, 1'b0);
    check("rise_busy", bus_a.busy, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("rise_lat2", bus_a.dout, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("fall_lat1", bus_a.dout, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // One-cycle pulse is swallowed; busy lasts one cycle.
    step(1'b1, 1'b0, 1'b0);
    check("pulse1_busy", bus_a.busy, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("pulse1_dout", bus_a.dout, 1'b0);
    check("pulse1_idle", bus_a.busy, 1'b0);

    // Two-cycle pulse passes, rising 2 cycles after the change.
    step(1'b1, 1'b0, 1'b0);
    check("pulse2_wait", bus_a.dout, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pulse2_rise", bus_a.dout, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Enable: on after 1 cycle, off 3 cycles after oe falls.
    step(1'b0, 1'b1, 1'b0);
    check("en_on_lat1", bus_a.dout_en, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("en_drain1", bus_a.dout_en, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("en_drain2", bus_a.dout_en, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("en_off_lat3", bus_a.dout_en, 1'b0);

    // oe low for only 2 cycles: dout_en never drops.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("en_glitch_hold", bus_a.dout_en, 1'b1);
    check("en_glitch_busy", bus_a.busy,    1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Data keeps tracking while disabled.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("settled_dout", bus_a.dout,    1'b1);
    check("settled_en",   bus_a.dout_en, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Slow rise: reset when the count has reached 7 aborts the rise.
    step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    check("slow_pending", bus_b.busy, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("abort_dout", bus_b.dout, 1'b0);
    check("abort_busy", bus_b.busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("abort_no_rise", bus_b.dout, 1'b0);
    end

    // First edge after reset is processed normally.
    step(1'b1, 1'b1, 1'b0);
    check("post_rst_en",  bus_c.dout_en, 1'b1);
    check("post_rst_din", bus_c.dout,    1'b1);

    // Randomized traffic, with the occasional reset.
    d = 1'b1;
    o = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) d = ~d;
      if ($urandom_range(0, 3) == 0) o = ~o;
      r = ($urandom_range(0, 63) == 0);
      step(d, o, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
